execid_seq: RTL and testbench

EXECID_SEQ -- requirements
Module: execid_seq

---
 rtl/execid_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_execid_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/execid_seq.sv
// Hierarchical execution-ID sequencer: ZERO/LOAD/INC/DESCEND/ASCEND on 8-bit slots of cur_id.
// Latency: rsp_valid high 2 cycles after the accept cycle (ZERO/LOAD/illegal), NSLOTS+2 for scanning ops.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
// Optional feature macro EXECID_SEQ_ERRCNT_EN: adds err_cnt, a saturating 8-bit error counter output.
module execid_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_id,
    output logic [1:0]       rsp_err,
    output logic [WIDTH-1:0] cur_id
`ifdef EXECID_SEQ_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int NSLOTS = WIDTH / 8;
    localparam int LW     = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
    localparam logic [LW-1:0] LAST_SLOT = LW'(NSLOTS - 1);

    localparam logic [2:0] OP_ZERO    = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_INC     = 3'd2;
    localparam logic [2:0] OP_DESCEND = 3'd3;
    localparam logic [2:0] OP_ASCEND  = 3'd4;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_NOSLOT = 2'd1;
    localparam logic [1:0] ERR_OVF    = 2'd2;
    localparam logic [1:0] ERR_BADOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        APPLY = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched command
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;

    // Scan results: lowest nonzero slot (lo) and highest zero slot (hz)
    logic [LW-1:0] scan_idx;
    logic [LW-1:0] lo;
    logic          lo_found;
    logic [LW-1:0] hz;
    logic          hz_found;

    // Slot views and candidate results
    logic [7:0]       scan_slot;
    logic [7:0]       lo_slot;
    logic [7:0]       up_slot;
    logic [WIDTH-1:0] inc_id;
    logic [WIDTH-1:0] desc_id;
    logic [WIDTH-1:0] asc_id;
    logic [WIDTH-1:0] op_id;
    logic [1:0]       apply_err;

    logic accept;

    // Only the slot-walking ops need to pass through SCAN.
    function automatic logic is_scan_op(input logic [2:0] op);
        return (op == OP_INC) || (op == OP_DESCEND) || (op == OP_ASCEND);
    endfunction

    assign accept = cmd_valid && cmd_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = is_scan_op(cmd_op) ? SCAN : APPLY;
                end
            end
            SCAN: begin
                if (scan_idx == LAST_SLOT) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = (state == IDLE);
    end

    // Capture op and data at accept so later input changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
        end
    end

    // Walk slots 0..NSLOTS-1, one per cycle, recording lo and hz
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= '0;
            lo       <= '0;
            lo_found <= 1'b0;
            hz       <= '0;
            hz_found <= 1'b0;
        end else if (accept) begin
            scan_idx <= '0;
            lo       <= '0;
            lo_found <= 1'b0;
            hz       <= '0;
            hz_found <= 1'b0;
        end else if (state == SCAN) begin
            if (scan_slot != 8'd0) begin
                // First nonzero seen wins: that is the innermost level.
                if (!lo_found) begin
                    lo       <= scan_idx;
                    lo_found <= 1'b1;
                end
            end else begin
                // Ascending walk, so the last zero seen is the highest one.
                hz       <= scan_idx;
                hz_found <= 1'b1;
            end
            if (scan_idx != LAST_SLOT) begin
                scan_idx <= scan_idx + LW'(1);
            end
        end
    end

    // Select the slot under scan, slot lo and slot lo+1 without dynamic part-selects
    always_comb begin
        scan_slot = 8'd0;
        lo_slot   = 8'd0;
        up_slot   = 8'd0;
        for (int k = 0; k < NSLOTS; k++) begin
            if (LW'(k) == scan_idx) begin
                scan_slot = cur_id[8*k +: 8];
            end
            if (LW'(k) == lo) begin
                lo_slot = cur_id[8*k +: 8];
            end
            if ((k > 0) && (LW'(k - 1) == lo)) begin
                up_slot = cur_id[8*k +: 8];
            end
        end
    end

    // Candidate IDs for INC/DESCEND/ASCEND; slot math wraps per slot, no carry between slots
    always_comb begin
        inc_id  = cur_id;
        desc_id = cur_id;
        asc_id  = cur_id;
        for (int k = 0; k < NSLOTS; k++) begin
            if (LW'(k) == lo) begin
                inc_id[8*k +: 8] = cur_id[8*k +: 8] + 8'd1;
                asc_id[8*k +: 8] = 8'd0;
            end
            if (LW'(k) == hz) begin
                desc_id[8*k +: 8] = 8'd1;
            end
            if ((k > 0) && (LW'(k - 1) == lo)) begin
                asc_id[8*k +: 8] = cur_id[8*k +: 8] + 8'd1;
            end
        end
    end

    // Pick the result and error code; any error leaves op_id at cur_id
    always_comb begin
        op_id     = cur_id;
        apply_err = ERR_OK;
        case (op_q)
            OP_ZERO: begin
                op_id = '0;
            end
            OP_LOAD: begin
                op_id = data_q;
            end
            OP_INC: begin
                if (!lo_found) begin
                    apply_err = ERR_NOSLOT;
                end else if (lo_slot == 8'hFF) begin
                    apply_err = ERR_OVF;
                end else begin
                    op_id = inc_id;
                end
            end
            OP_DESCEND: begin
                if (!hz_found) begin
                    apply_err = ERR_NOSLOT;
                end else begin
                    op_id = desc_id;
                end
            end
            OP_ASCEND: begin
                if (!lo_found || (lo == LAST_SLOT)) begin
                    apply_err = ERR_NOSLOT;
                end else if (up_slot == 8'hFF) begin
                    apply_err = ERR_OVF;
                end else begin
                    op_id = asc_id;
                end
            end
            default: begin
                apply_err = ERR_BADOP;
            end
        endcase
    end

    // Commit cur_id and the response together on the APPLY edge; drop rsp_valid on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id    <= '0;
            rsp_id    <= '0;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b0;
        end else if (state == APPLY) begin
            cur_id    <= op_id;
            rsp_id    <= op_id;
            rsp_err   <= apply_err;
            rsp_valid <= 1'b1;
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef EXECID_SEQ_ERRCNT_EN
    // Count failed commands, saturating at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if ((state == APPLY) && (apply_err != ERR_OK) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execid_seq.sv
`timescale 1ns/1ps
module tb_execid_seq;

    localparam int WIDTH  = 32;
    localparam int NSLOTS = WIDTH / 8;

    localparam logic [2:0] ZERO = 3'd0, LOAD = 3'd1, INC = 3'd2, DESC = 3'd3, ASC = 3'd4;
    localparam logic [1:0] OK = 2'd0, NOSLOT = 2'd1, OVF = 2'd2, BADOP = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_id;
    logic [1:0]       rsp_err;
    logic [WIDTH-1:0] cur_id;
`ifdef EXECID_SEQ_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    always #5 clk = ~clk;

    execid_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .cur_id    (cur_id)
`ifdef EXECID_SEQ_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] id;
        logic [1:0]  err;
        logic [7:0]  lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] id;
        logic [1:0]  err;
        int          hold;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[26];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from the accept cycle (cycle 0) to the first cycle with rsp_valid high.
    function automatic logic [7:0] lat_of(input logic [2:0] op);
        return (op == INC || op == DESC || op == ASC) ? 8'(NSLOTS + 2) : 8'd2;
    endfunction

    // Issue one command, expect one response; hold = cycles to keep rsp_ready low after rsp_valid.
    task automatic send(input logic [2:0] op, input logic [31:0] data,
                        input logic [31:0] exp_id, input logic [1:0] exp_err, input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.id  = exp_id;
        e.err = exp_err;
        e.lat = lat_of(op);
        sb_q.push_back(e);
        @(negedge clk);
        // Scramble the command inputs while the command is in flight.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom_range(0, 7));
        cmd_data  = $urandom;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        check("rsp_latency", 32'(cyc), 32'(e.lat));
        if (!rsp_valid) return;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_id", rsp_id, e.id);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        check("rsp_id", rsp_id, e.id);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("cur_id", cur_id, e.id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        vecs[0]  = '{DESC, 32'h0,        32'h01000000, OK,     0};
        vecs[1]  = '{LOAD, 32'h01000000, 32'h01000000, OK,     0};
        vecs[2]  = '{DESC, 32'h0,        32'h01010000, OK,     0};
        vecs[3]  = '{INC,  32'h0,        32'h01020000, OK,     0};
        vecs[4]  = '{INC,  32'h0,        32'h01030000, OK,     0};
        vecs[5]  = '{LOAD, 32'h0102FF00, 32'h0102FF00, OK,     0};
        // lo is slot 1 (0xFF), slot 2 holds 0x02, so this ascends cleanly.
        vecs[6]  = '{ASC,  32'h0,        32'h01030000, OK,     0};
        vecs[7]  = '{LOAD, 32'h01FF0300, 32'h01FF0300, OK,     0};
        // Here the slot above lo is 0xFF.
        vecs[8]  = '{ASC,  32'h0,        32'h01FF0300, OVF,    0};
        vecs[9]  = '{LOAD, 32'h01020300, 32'h01020300, OK,     0};
        vecs[10] = '{ASC,  32'h0,        32'h01030000, OK,     0};
        vecs[11] = '{LOAD, 32'h010101FF, 32'h010101FF, OK,     0};
        vecs[12] = '{INC,  32'h0,        32'h010101FF, OVF,    0};
        vecs[13] = '{DESC, 32'h0,        32'h010101FF, NOSLOT, 0};
        vecs[14] = '{ZERO, 32'h0,        32'h00000000, OK,     0};
        vecs[15] = '{ASC,  32'h0,        32'h00000000, NOSLOT, 0};
        vecs[16] = '{LOAD, 32'h05000000, 32'h05000000, OK,     0};
        vecs[17] = '{ASC,  32'h0,        32'h05000000, NOSLOT, 0};
        vecs[18] = '{3'd6, 32'hDEADBEEF, 32'h05000000, BADOP,  10};
        vecs[19] = '{INC,  32'h0,        32'h06000000, OK,     0};
        vecs[20] = '{3'd5, 32'h0,        32'h06000000, BADOP,  0};
        vecs[21] = '{3'd7, 32'h0,        32'h06000000, BADOP,  0};
        vecs[22] = '{LOAD, 32'h00000001, 32'h00000001, OK,     3};
        vecs[23] = '{ASC,  32'h0,        32'h00000100, OK,     0};
        vecs[24] = '{DESC, 32'h0,        32'h01000100, OK,     0};
        vecs[25] = '{INC,  32'h0,        32'h01000200, OK,     0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_cur_id", cur_id, 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", rsp_id, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef EXECID_SEQ_ERRCNT_EN
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif

        for (int i = 0; i < 26; i++) begin
            send(vecs[i].op, vecs[i].data, vecs[i].id, vecs[i].err, vecs[i].hold);
        end
`ifdef EXECID_SEQ_ERRCNT_EN
        check("table_err_cnt", 32'(err_cnt), 32'd8);
`endif

        // Reset during the second SCAN cycle abandons the command.
        send(LOAD, 32'h01000000, 32'h01000000, OK, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = INC;
        cmd_data  = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("scan_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_cur_id", cur_id, 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < NSLOTS + 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_cur_id_hold", cur_id, 32'h0);

`ifdef EXECID_SEQ_ERRCNT_EN
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        send(ASC,  32'h0, 32'h0, NOSLOT, 0);
        send(3'd6, 32'h0, 32'h0, BADOP,  0);
        send(INC,  32'h0, 32'h0, NOSLOT, 0);
        check("three_err_cnt", 32'(err_cnt), 32'd3);
`endif

        // Post-reset DESCEND again, to confirm the sequencer is fully usable.
        send(DESC, 32'h0, 32'h01000000, OK, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
